// File: rtl/alu_dec_unit_if.sv
// Operand/result bundle for alu_dec_unit: ALU, decoder and counter signals.
// The consumer (the unit itself) takes the slave view; the driver takes master.
interface alu_dec_unit_if;
   logic [2:0] alu_fnselec;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_res;
   logic       alu_zero;
   logic       alu_overflow;
   logic       alu_carry;
   logic [2:0] dec_x;
   logic       dec_en;
   logic [7:0] dec_y;
   logic       cnt_en;
   logic [2:0] cnt_q;

   modport master (
      output alu_fnselec, alu_a, alu_b, dec_x, dec_en, cnt_en,
      input  alu_res, alu_zero, alu_overflow, alu_carry, dec_y, cnt_q
   );

   modport slave (
      input  alu_fnselec, alu_a, alu_b, dec_x, dec_en, cnt_en,
      output alu_res, alu_zero, alu_overflow, alu_carry, dec_y, cnt_q
   );
endinterface

// File: rtl/alu_dec_unit.sv
// 4-bit ALU + 3:8 one-hot decoder (combinational) and a 3-bit wrapping down-counter.
// Latency: ALU/decoder zero, counter one clk edge; no backpressure, free-running.
module alu_dec_unit (
   input  logic           clk,
   input  logic           resetn,
   alu_dec_unit_if.slave  bus
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_NOT = 3'b010,
      OP_AND = 3'b011,
      OP_OR  = 3'b100,
      OP_XOR = 3'b101,
      OP_LT  = 3'b110,
      OP_EQ  = 3'b111
   } alu_op_e;

   logic [4:0] w_add_sum;
   logic [4:0] w_sub_sum;
   logic       w_add_ovf;
   logic       w_sub_ovf;
   logic       w_lt;
   logic [3:0] w_res;
   logic       w_carry;
   logic       w_ovf;
   logic [7:0] w_dec_y;
   logic [2:0] r_cnt;

   // SUB carry out of A + ~B + 1 is the inverted borrow.
   assign w_add_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
   assign w_sub_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;

   assign w_add_ovf = (bus.alu_a[3] == bus.alu_b[3]) && (w_add_sum[3] != bus.alu_a[3]);
   assign w_sub_ovf = (bus.alu_a[3] != bus.alu_b[3]) && (w_sub_sum[3] != bus.alu_a[3]);

   // Signed less-than: the difference's sign is only trustworthy without overflow.
   assign w_lt = w_sub_sum[3] ^ w_sub_ovf;

   always_comb begin
      w_res   = 4'h0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (alu_op_e'(bus.alu_fnselec))
         OP_ADD: begin
            w_res   = w_add_sum[3:0];
            w_carry = w_add_sum[4];
            w_ovf   = w_add_ovf;
         end
         OP_SUB: begin
            w_res   = w_sub_sum[3:0];
            w_carry = w_sub_sum[4];
            w_ovf   = w_sub_ovf;
         end
         OP_NOT:  w_res = ~bus.alu_a;
         OP_AND:  w_res = bus.alu_a & bus.alu_b;
         OP_OR:   w_res = bus.alu_a | bus.alu_b;
         OP_XOR:  w_res = bus.alu_a ^ bus.alu_b;
         OP_LT:   w_res = {3'b000, w_lt};
         OP_EQ:   w_res = {3'b000, (bus.alu_a == bus.alu_b)};
         default: w_res = 4'h0;
      endcase
   end

   assign bus.alu_res      = w_res;
   assign bus.alu_zero     = (w_res == 4'h0);
   assign bus.alu_carry    = w_carry;
   assign bus.alu_overflow = w_ovf;

   always_comb begin
      w_dec_y = 8'h00;
      if (bus.dec_en) begin
         w_dec_y[bus.dec_x] = 1'b1;
      end
   end

   assign bus.dec_y = w_dec_y;

   // Natural 3-bit wrap takes 0 back to 7.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= 3'b111;
      end else if (bus.cnt_en) begin
         r_cnt <= r_cnt - 3'd1;
      end
   end

   assign bus.cnt_q = r_cnt;

endmodule

// File: tb/tb_alu_dec_unit.sv
// Randomized + directed bench for alu_dec_unit against an arithmetic reference model.
module tb_alu_dec_unit;

   logic clk    = 1'b0;
   logic resetn = 1'b1;
   bit   chk_on = 1'b0;
   int   n_vec  = 0;
   int   n_err  = 0;
   int   m_cnt  = 7;

   alu_dec_unit_if bus ();

   alu_dec_unit u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sx4(input int v);
      return (v >= 8) ? v - 16 : v;
   endfunction

   // Reference from integer arithmetic on the operand values.
   function automatic void ref_alu(input int fn, input int a, input int b,
                                   output int res, output int z,
                                   output int c, output int v);
      int r;
      int s;
      r = 0;
      c = 0;
      v = 0;
      case (fn)
         0: begin
            r = a + b;
            c = (r > 15) ? 1 : 0;
            s = sx4(a) + sx4(b);
            v = (s > 7 || s < -8) ? 1 : 0;
         end
         1: begin
            r = a - b + 16;
            c = (a >= b) ? 1 : 0;
            s = sx4(a) - sx4(b);
            v = (s > 7 || s < -8) ? 1 : 0;
         end
         2: r = 15 - a;
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = (sx4(a) < sx4(b)) ? 1 : 0;
         default: r = (a == b) ? 1 : 0;
      endcase
      res = r % 16;
      z   = (res == 0) ? 1 : 0;
   endfunction

   // Counter model: value held, decremented mod 8, forced to 7 on reset.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) m_cnt = 7;
      else if (bus.cnt_en) m_cnt = (m_cnt + 7) % 8;
   end

   always @(negedge clk) begin
      if (chk_on) begin
         int er, ez, ec, ev;
         ref_alu(int'(bus.alu_fnselec), int'(bus.alu_a), int'(bus.alu_b), er, ez, ec, ev);
         chk("alu_res", int'(bus.alu_res), er);
         chk("alu_zero", int'(bus.alu_zero), ez);
         chk("alu_carry", int'(bus.alu_carry), ec);
         chk("alu_overflow", int'(bus.alu_overflow), ev);
         chk("dec_y", int'(bus.dec_y), bus.dec_en ? (1 << bus.dec_x) : 0);
         chk("cnt_q", int'(bus.cnt_q), m_cnt);
      end
   end

   task automatic lit_alu(input int fn, input int a, input int b,
                          input int er, input int ez, input int ec, input int ev);
      bus.alu_fnselec = 3'(fn);
      bus.alu_a       = 4'(a);
      bus.alu_b       = 4'(b);
      #1;
      chk("lit_res", int'(bus.alu_res), er);
      chk("lit_zero", int'(bus.alu_zero), ez);
      chk("lit_carry", int'(bus.alu_carry), ec);
      chk("lit_ovf", int'(bus.alu_overflow), ev);
   endtask

   initial begin
      int exp_seq [8];
      exp_seq = '{6, 5, 4, 3, 2, 1, 0, 7};

      bus.alu_fnselec = 3'd0;
      bus.alu_a       = 4'd0;
      bus.alu_b       = 4'd0;
      bus.dec_x       = 3'd0;
      bus.dec_en      = 1'b0;
      bus.cnt_en      = 1'b1;
      #2 resetn = 1'b0;
      #1;
      chk("reset_cnt_q", int'(bus.cnt_q), 7);
      chk("reset_dec_y", int'(bus.dec_y), 0);
      chk_on = 1'b1;

      // Reset held across edges with cnt_en high: counter must stay at 7.
      repeat (2) @(posedge clk);
      #1 chk("reset_hold", int'(bus.cnt_q), 7);

      lit_alu(0, 4'b0111, 4'b0001, 4'b1000, 0, 0, 1);
      lit_alu(0, 4'b1111, 4'b0001, 4'b0000, 1, 1, 0);
      lit_alu(1, 4'b1000, 4'b0001, 4'b0111, 0, 1, 1);
      lit_alu(6, 4'b1000, 4'b0001, 4'b0001, 0, 0, 0);
      lit_alu(6, 4'b0011, 4'b1110, 4'b0000, 1, 0, 0);
      lit_alu(3, 4'b1010, 4'b0110, 4'b0010, 0, 0, 0);
      lit_alu(4, 4'b1010, 4'b0110, 4'b1110, 0, 0, 0);
      lit_alu(5, 4'b1010, 4'b0110, 4'b1100, 0, 0, 0);
      lit_alu(2, 4'b1010, 4'b0110, 4'b0101, 0, 0, 0);
      lit_alu(7, 4'b0101, 4'b0101, 4'b0001, 0, 0, 0);
      lit_alu(7, 4'b0101, 4'b0100, 4'b0000, 1, 0, 0);

      bus.dec_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.dec_x = 3'(i);
         #1 chk("dec_sweep", int'(bus.dec_y), 1 << i);
      end
      bus.dec_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.dec_x = 3'(i);
         #1 chk("dec_off", int'(bus.dec_y), 0);
      end

      @(posedge clk);
      #1 resetn = 1'b1;
      chk("cnt_start", int'(bus.cnt_q), 7);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1 chk("cnt_seq", int'(bus.cnt_q), exp_seq[k]);
      end
      bus.cnt_en = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1 chk("cnt_hold", int'(bus.cnt_q), 7);
      end
      // Toggle enable between edges only; the sampled value at the edge is 0.
      #2 bus.cnt_en = 1'b1;
      #2 bus.cnt_en = 1'b0;
      @(posedge clk);
      #1 chk("cnt_glitch", int'(bus.cnt_q), 7);

      bus.cnt_en = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("cnt_at_2", int'(bus.cnt_q), 2);
      #2 resetn = 1'b0;
      #1 chk("async_rst", int'(bus.cnt_q), 7);
      @(posedge clk);
      #1 resetn = 1'b1;
      chk("rst_release", int'(bus.cnt_q), 7);
      @(posedge clk);
      #1 chk("resume", int'(bus.cnt_q), 6);

      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         bus.alu_fnselec = 3'($urandom_range(0, 7));
         bus.alu_a       = 4'($urandom_range(0, 15));
         bus.alu_b       = ($urandom_range(0, 7) == 0) ? bus.alu_a : 4'($urandom_range(0, 15));
         bus.dec_x       = 3'($urandom_range(0, 7));
         bus.dec_en      = 1'($urandom_range(0, 1));
         bus.cnt_en      = ($urandom_range(0, 3) != 0);
         resetn          = ($urandom_range(0, 63) != 0);
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
